// File: rtl/control_defs.sv
// Shared fetch-path definitions: default sizing, reset vector and the buffered entry format.
package control_defs;

  localparam int unsigned DefaultDepth   = 4;
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

  // One decoded-ready instruction as held in the instruction buffer.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with occupancy count and flush; used for the instruction buffer
// and for the in-order PC queue of outstanding requests.
module fetch_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy update; flush has priority over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited sequential requests, in-order response
// matching through a PC queue, an instruction buffer, and redirect with stale-response drop.
module fetch_unit
  import control_defs::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc,
  parameter int unsigned DEPTH    = DefaultDepth
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned SumW = CntW + 1;

  logic [31:0]     pc_q, pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_q, drop_d;

  fetch_entry_t    inst_head, inst_wdata;
  logic            inst_empty, inst_full;
  logic [CntW-1:0] inst_count;
  logic [31:0]     pcq_head;
  logic            pcq_empty, pcq_full;
  logic [CntW-1:0] pcq_count;

  logic            req_fire, rsp_keep, rsp_drop, inst_fire;
  logic [SumW-1:0] credit_sum;

  // Credits come from registered counts only, so a consume frees a slot one cycle later.
  assign credit_sum     = {1'b0, outstanding_q} + {1'b0, inst_count};
  assign imem_req_valid = !rst && !redirect_valid && (credit_sum < SumW'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop  = imem_rsp_valid && (drop_q != '0);
  assign rsp_keep  = imem_rsp_valid && (drop_q == '0);
  assign inst_fire = inst_valid && inst_ready;

  assign inst_wdata.pc   = pcq_head;
  assign inst_wdata.inst = imem_rsp_data;

  assign inst_valid = !inst_empty;
  assign inst_data  = inst_empty ? 32'h0 : inst_head.inst;
  assign inst_pc    = inst_empty ? 32'h0 : inst_head.pc;

  // Fetch PC, in-flight count and drop count next state.
  always_comb begin
    pc_d          = pc_q;
    drop_d        = drop_q;
    outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(imem_rsp_valid);
    if (redirect_valid) begin
      pc_d   = {redirect_pc[31:2], 2'b00};
      // Every request still in flight is now stale; those already doomed are included.
      drop_d = outstanding_q - CntW'(imem_rsp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (rsp_drop) drop_d = drop_q - CntW'(1);
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_fifo #(
    .Width ($bits(fetch_entry_t)),
    .Depth (DEPTH)
  ) u_inst_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (rsp_keep),
    .data_i  (inst_wdata),
    .pop_i   (inst_fire),
    .data_o  (inst_head),
    .full_o  (inst_full),
    .empty_o (inst_empty),
    .count_o (inst_count)
  );

  fetch_fifo #(
    .Width (32),
    .Depth (DEPTH)
  ) u_pc_queue (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (req_fire),
    .data_i  (pc_q),
    .pop_i   (rsp_keep),
    .data_o  (pcq_head),
    .full_o  (pcq_full),
    .empty_o (pcq_empty),
    .count_o (pcq_count)
  );

  a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outstanding_q != '0));
  a_rsp_has_pc: assert property (@(posedge clk) disable iff (rst)
    rsp_keep |-> !pcq_empty);
  a_pcq_no_overflow: assert property (@(posedge clk) disable iff (rst)
    req_fire |-> !pcq_full);
  a_pcq_bounded: assert property (@(posedge clk) disable iff (rst)
    pcq_count <= outstanding_q);
  a_inst_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (rsp_keep && !redirect_valid) |-> (!inst_full || inst_fire));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with programmable latency, expected-instruction
// scoreboard, a redirect vector table and directed multi-cycle sequences.
module tb_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;

  fetch_unit #(
    .RESET_PC (ResetPc),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; int due;} pend_t;
  typedef struct {logic [31:0] pc; logic [31:0] data;} exp_t;
  typedef struct {logic [31:0] rpc; logic [31:0] first; logic [31:0] second;} redir_vec_t;

  pend_t pend[$];
  exp_t  exp_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int lat = 1;

  // Staged stimulus, applied at the next falling edge.
  logic        t_rst = 1'b1, t_req_ready = 1'b1, t_inst_ready = 1'b1, t_redir = 1'b0;
  logic [31:0] t_redir_pc = 32'h0;
  logic [31:0] mdl_pc = ResetPc;

  // Observations of the most recent cycle.
  logic        obs_fire, obs_xfer, obs_rsp, obs_req_valid, obs_inst_valid;
  logic [31:0] obs_addr, obs_inst_pc, obs_inst_data;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, serve memory, sample outputs, update the scoreboard.
  task automatic step();
    @(negedge clk);
    rst            = t_rst;
    imem_req_ready = t_req_ready;
    inst_ready     = t_inst_ready;
    redirect_valid = t_redir;
    redirect_pc    = t_redir_pc;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (t_rst) begin
      pend.delete();
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end
    #1;
    obs_req_valid  = imem_req_valid;
    obs_fire       = imem_req_valid && imem_req_ready;
    obs_xfer       = inst_valid && inst_ready;
    obs_rsp        = imem_rsp_valid;
    obs_addr       = imem_req_addr;
    obs_inst_valid = inst_valid;
    obs_inst_pc    = inst_pc;
    obs_inst_data  = inst_data;
    if (t_rst) begin
      exp_q.delete();
      mdl_pc = ResetPc;
    end else begin
      if (inst_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL stale_inst: got pc %h want no instruction (cycle %0d)", inst_pc, cyc);
        end else begin
          chk("inst_pc", inst_pc, exp_q[0].pc);
          chk("inst_data", inst_data, exp_q[0].data);
          if (inst_ready) void'(exp_q.pop_front());
        end
      end
      if (redirect_valid) begin
        exp_q.delete();
        mdl_pc = {redirect_pc[31:2], 2'b00};
      end else if (obs_fire) begin
        chk("req_addr", imem_req_addr, mdl_pc);
        exp_q.push_back('{pc: mdl_pc, data: mem_word(mdl_pc)});
        pend.push_back('{addr: mdl_pc, due: cyc + lat});
        mdl_pc = mdl_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    t_rst = 1'b1;
    step();
    step();
    t_rst = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!obs_inst_valid && n < 40) begin
      step();
      n++;
    end
    n_cmp++;
    if (!obs_inst_valid) begin
      n_fail++;
      $display("FAIL %s: got no inst_valid want inst_valid within 40 cycles", nm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    redir_vec_t vec[6];
    int cnt;
    logic [31:0] last_addr;

    vec[0] = '{rpc: 32'h0000_0203, first: 32'h0000_0200, second: 32'h0000_0204};
    vec[1] = '{rpc: 32'h0000_0100, first: 32'h0000_0100, second: 32'h0000_0104};
    vec[2] = '{rpc: 32'h0000_1001, first: 32'h0000_1000, second: 32'h0000_1004};
    vec[3] = '{rpc: 32'h8000_0006, first: 32'h8000_0004, second: 32'h8000_0008};
    vec[4] = '{rpc: 32'hffff_fffe, first: 32'hffff_fffc, second: 32'h0000_0000};
    vec[5] = '{rpc: 32'hffff_fff8, first: 32'hffff_fff8, second: 32'hffff_fffc};

    rst = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = 32'h0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

    // Reset values.
    t_rst = 1'b1;
    step();
    chk("rst_req_valid", 32'(obs_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(obs_inst_valid), 32'd0);
    chk("rst_inst_data", obs_inst_data, 32'h0);
    chk("rst_inst_pc", obs_inst_pc, 32'h0);
    chk("rst_req_addr", obs_addr, ResetPc);

    // Release with 1-cycle memory, consumer always ready.
    lat = 1; t_inst_ready = 1'b1; t_req_ready = 1'b1;
    do_reset();
    step();
    chk("c0_fire", 32'(obs_fire), 32'd1);
    chk("c0_addr", obs_addr, 32'h0);
    chk("c0_inst_valid", 32'(obs_inst_valid), 32'd0);
    step();
    chk("c1_inst_valid", 32'(obs_inst_valid), 32'd0);
    chk("c1_addr", obs_addr, 32'h4);
    step();
    chk("c2_inst_valid", 32'(obs_inst_valid), 32'd1);
    chk("c2_inst_pc", obs_inst_pc, 32'h0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (obs_xfer) cnt++;
    end
    chk("sustained_xfers", 32'(cnt), 32'd8);

    // Consumer stalled: the credit limit stops fetch after four requests.
    t_inst_ready = 1'b0;
    do_reset();
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs_fire) begin cnt++; last_addr = obs_addr; end
    end
    chk("stall_req_count", 32'(cnt), 32'd4);
    chk("stall_last_addr", last_addr, 32'hc);
    chk("stall_req_valid", 32'(obs_req_valid), 32'd0);
    chk("stall_head_pc", obs_inst_pc, 32'h0);
    chk("stall_head_data", obs_inst_data, mem_word(32'h0));
    t_inst_ready = 1'b1;
    step();
    chk("pulse_xfer", 32'(obs_xfer), 32'd1);
    t_inst_ready = 1'b0;
    cnt = obs_fire ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (obs_fire) begin cnt++; last_addr = obs_addr; end
    end
    chk("pulse_req_count", 32'(cnt), 32'd1);
    chk("pulse_req_addr", last_addr, 32'h10);

    // Redirect with two requests in flight at 3-cycle latency.
    lat = 3; t_inst_ready = 1'b1;
    do_reset();
    step();
    step();
    t_redir = 1'b1; t_redir_pc = 32'h100;
    step();
    chk("redir_no_req", 32'(obs_req_valid), 32'd0);
    chk("redir_in_flight", 32'(pend.size()), 32'd2);
    t_redir = 1'b0;
    step();
    wait_valid("redir_first_wait");
    chk("redir_first_pc", obs_inst_pc, 32'h100);
    step();
    wait_valid("redir_second_wait");
    chk("redir_second_pc", obs_inst_pc, 32'h104);

    // Redirect vector table at 1-cycle latency.
    lat = 1;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    foreach (vec[i]) begin
      t_redir = 1'b1; t_redir_pc = vec[i].rpc;
      step();
      chk("vec_redir_req_valid", 32'(obs_req_valid), 32'd0);
      t_redir = 1'b0;
      step();
      chk("vec_after_inst_valid", 32'(obs_inst_valid), 32'd0);
      chk("vec_first_fire", 32'(obs_fire), 32'd1);
      chk("vec_first_addr", obs_addr, vec[i].first);
      step();
      chk("vec_second_fire", 32'(obs_fire), 32'd1);
      chk("vec_second_addr", obs_addr, vec[i].second);
      step();
    end

    // Redirect in a cycle that also carries a transfer and a response.
    for (int i = 0; i < 4; i++) step();
    t_redir = 1'b1; t_redir_pc = 32'h400;
    step();
    chk("coinc_xfer", 32'(obs_xfer), 32'd1);
    chk("coinc_rsp", 32'(obs_rsp), 32'd1);
    t_redir = 1'b0;
    step();
    wait_valid("coinc_wait");
    chk("coinc_next_pc", obs_inst_pc, 32'h400);

    // Reset mid-stream takes effect immediately and restarts at the reset vector.
    for (int i = 0; i < 3; i++) step();
    t_rst = 1'b1;
    step();
    chk("mid_rst_req_valid", 32'(obs_req_valid), 32'd0);
    chk("mid_rst_inst_valid", 32'(obs_inst_valid), 32'd0);
    chk("mid_rst_inst_data", obs_inst_data, 32'h0);
    chk("mid_rst_inst_pc", obs_inst_pc, 32'h0);
    chk("mid_rst_addr", obs_addr, ResetPc);
    t_rst = 1'b0;
    step();
    chk("restart_fire", 32'(obs_fire), 32'd1);
    chk("restart_addr", obs_addr, ResetPc);

    // Random back-pressure on both sides with occasional redirects.
    lat = 2;
    for (int i = 0; i < 80; i++) begin
      t_req_ready  = 1'($urandom_range(0, 1));
      t_inst_ready = 1'($urandom_range(0, 1));
      t_redir      = ($urandom_range(0, 15) == 0);
      t_redir_pc   = $urandom;
      step();
    end
    t_redir = 1'b0; t_req_ready = 1'b1; t_inst_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
